// File: rtl/collision_engine.sv
// collision_engine: pipelined ball-versus-paddle collision detector.
// Stage 1 registers per-paddle overlap, struck face and penetration depth.
// Stage 2 turns new contacts into queued one-cycle hit events, reported
// lowest index first, with a per-paddle frame cooldown after each report.
module collision_engine #(
    parameter int N_PADDLES   = 2,
    parameter int W           = 10,
    parameter int COOL_FRAMES = 4,
    localparam int IW = (N_PADDLES > 1) ? $clog2(N_PADDLES) : 1
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [W-1:0]           ball_x,
    input  logic [W-1:0]           ball_y,
    input  logic [W-1:0]           ball_w,
    input  logic [W-1:0]           ball_h,
    input  logic [N_PADDLES*W-1:0] paddle_x,
    input  logic [N_PADDLES*W-1:0] paddle_y,
    input  logic [N_PADDLES*W-1:0] paddle_w,
    input  logic [N_PADDLES*W-1:0] paddle_h,
    output logic [N_PADDLES-1:0]   collide_mask,
    output logic                   hit_valid,
    output logic [IW-1:0]          hit_idx,
    output logic [1:0]             hit_side,
    output logic [W:0]             hit_depth
);

    localparam int CW = (COOL_FRAMES > 0) ? $clog2(COOL_FRAMES + 1) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOL_FRAMES);

    // Minimum of the four face depths; ties resolve left > right > top > bottom.
    // Returns {side, depth}.
    function automatic logic [W+2:0] min_face(input logic [W:0] dl, input logic [W:0] dr,
                                              input logic [W:0] dt, input logic [W:0] db);
        logic [1:0] s;
        logic [W:0] m;
        s = 2'd0;
        m = dl;
        if (dr < m) begin s = 2'd1; m = dr; end
        if (dt < m) begin s = 2'd2; m = dt; end
        if (db < m) begin s = 2'd3; m = db; end
        return {s, m};
    endfunction

    // Stage 1 combinational: W+1 bit edges so x+w / y+h never wrap.
    logic [N_PADDLES-1:0] ovl_d;
    logic [1:0]           side_d  [N_PADDLES];
    logic [W:0]           depth_d [N_PADDLES];
    logic [W:0]           bx_lo, bx_hi, by_lo, by_hi;
    logic [W:0]           px_lo [N_PADDLES];
    logic [W:0]           px_hi [N_PADDLES];
    logic [W:0]           py_lo [N_PADDLES];
    logic [W:0]           py_hi [N_PADDLES];

    // Overlap test and face/depth selection for every paddle.
    always_comb begin
        ovl_d = '0;
        bx_lo = {1'b0, ball_x};
        bx_hi = {1'b0, ball_x} + {1'b0, ball_w};
        by_lo = {1'b0, ball_y};
        by_hi = {1'b0, ball_y} + {1'b0, ball_h};
        for (int i = 0; i < N_PADDLES; i++) begin
            px_lo[i] = {1'b0, paddle_x[i*W +: W]};
            px_hi[i] = {1'b0, paddle_x[i*W +: W]} + {1'b0, paddle_w[i*W +: W]};
            py_lo[i] = {1'b0, paddle_y[i*W +: W]};
            py_hi[i] = {1'b0, paddle_y[i*W +: W]} + {1'b0, paddle_h[i*W +: W]};
            ovl_d[i] = (bx_lo <= px_hi[i]) && (bx_hi >= px_lo[i]) &&
                       (by_lo <= py_hi[i]) && (by_hi >= py_lo[i]);
            {side_d[i], depth_d[i]} = min_face(bx_hi - px_lo[i], px_hi[i] - bx_lo,
                                               by_hi - py_lo[i], py_hi[i] - by_lo);
        end
    end

    // ---- Stage 1 registers ----
    logic [N_PADDLES-1:0] ovl_q, prev_q;
    logic [1:0]           side_q  [N_PADDLES];
    logic [W:0]           depth_q [N_PADDLES];

    // Overlap level and its one-cycle history for edge detection.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            ovl_q  <= '0;
            prev_q <= '0;
        end else begin
            ovl_q  <= ovl_d;
            prev_q <= ovl_q;
        end
    end

    // Face and depth travel beside the overlap bit; only meaningful when it is set.
    always_ff @(posedge pixel_clk) begin
        for (int i = 0; i < N_PADDLES; i++) begin
            side_q[i]  <= side_d[i];
            depth_q[i] <= depth_d[i];
        end
    end

    assign collide_mask = ovl_q;

    // ---- Stage 2: event queue, cooldown and reporting ----
    logic [N_PADDLES-1:0] rise, accept, clr, pending_d, pending_q;
    logic [CW-1:0]        cool_d [N_PADDLES];
    logic [CW-1:0]        cool_q [N_PADDLES];
    logic [1:0]           buf_side_q  [N_PADDLES];
    logic [W:0]           buf_depth_q [N_PADDLES];
    logic                 sel_found;
    logic [IW-1:0]        sel_idx;
    logic [1:0]           sel_side;
    logic [W:0]           sel_depth;

    // Accept new contacts, pick the lowest pending event, update cooldowns.
    always_comb begin
        rise      = ovl_q & ~prev_q;
        accept    = '0;
        clr       = '0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_side  = '0;
        sel_depth = '0;
        for (int i = 0; i < N_PADDLES; i++) begin
            accept[i] = rise[i] && !pending_q[i] && (cool_q[i] == '0);
            if (pending_q[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_side  = buf_side_q[i];
                sel_depth = buf_depth_q[i];
                clr[i]    = 1'b1;
            end
        end
        pending_d = (pending_q | accept) & ~clr;
        for (int i = 0; i < N_PADDLES; i++) begin
            cool_d[i] = cool_q[i];
            if (frame_tick && (cool_q[i] != '0))
                cool_d[i] = cool_q[i] - 1'b1;
            if (clr[i])
                cool_d[i] = COOL_LOAD;
        end
    end

    // Pending bits and cooldown counters.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            pending_q <= '0;
            for (int i = 0; i < N_PADDLES; i++) cool_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < N_PADDLES; i++) cool_q[i] <= cool_d[i];
        end
    end

    // Event buffer keeps the face/depth seen at the moment of contact.
    always_ff @(posedge pixel_clk) begin
        for (int i = 0; i < N_PADDLES; i++) begin
            if (accept[i]) begin
                buf_side_q[i]  <= side_q[i];
                buf_depth_q[i] <= depth_q[i];
            end
        end
    end

    // ---- Stage 2 output register ----
    logic          hit_valid_q;
    logic [IW-1:0] hit_idx_q;
    logic [1:0]    hit_side_q;
    logic [W:0]    hit_depth_q;

    // One-cycle hit strobe; payload is zero when no event is reported.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            hit_side_q  <= '0;
            hit_depth_q <= '0;
        end else begin
            hit_valid_q <= sel_found;
            hit_idx_q   <= sel_idx;
            hit_side_q  <= sel_side;
            hit_depth_q <= sel_depth;
        end
    end

    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;
    assign hit_side  = hit_side_q;
    assign hit_depth = hit_depth_q;

endmodule
